// File: rtl/slot_counter_bank.sv
// Bank of independent up/down counters with wrap/saturate modes and a
// four-phase snapshot handshake that copies all live counts into slot words.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | waiting for snap_req
//   CAPTURE | slots latch this cycle's count_out on the next edge
//   ACK     | snap_ack high, waiting for snap_req to drop
module slot_counter_bank #(
    parameter int CHANNELS   = 4,
    parameter int WIDTH      = 8,
    parameter int SLOT_WIDTH = 32
) (
    input  logic                           slower_clock,
    input  logic                           rst,
    input  logic [CHANNELS-1:0]            en,
    input  logic [CHANNELS-1:0]            dir,
    input  logic [CHANNELS-1:0]            sat,
    input  logic [CHANNELS-1:0]            load,
    input  logic [CHANNELS*WIDTH-1:0]      load_value,
    input  logic                           clear,
    input  logic                           snap_req,
    output logic                           snap_ack,
    output logic [CHANNELS*WIDTH-1:0]      count_out,
    output logic [CHANNELS*SLOT_WIDTH-1:0] slots_out,
    output logic [CHANNELS-1:0]            wrap_pulse,
    output logic [CHANNELS-1:0]            ovf_sticky
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_ACK     = 2'd2
    } state_t;

    state_t                          r_state;
    state_t                          w_next_state;
    logic                            r_ack;
    logic [CHANNELS*SLOT_WIDTH-1:0]  r_slots;
    logic [CHANNELS*SLOT_WIDTH-1:0]  w_snap;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        logic [WIDTH-1:0] r_count;
        logic             r_wrap;
        logic             r_ovf;
        logic             w_at_bound;
        logic [WIDTH-1:0] w_step;

        // Boundary is all-ones when counting up, zero when counting down.
        assign w_at_bound = dir[i] ? (r_count == '0) : (&r_count);
        assign w_step     = dir[i] ? (r_count - WIDTH'(1)) : (r_count + WIDTH'(1));

        always_ff @(posedge slower_clock or posedge rst) begin
            if (rst) begin
                r_count <= '0;
                r_wrap  <= 1'b0;
                r_ovf   <= 1'b0;
            end else if (clear) begin
                r_count <= '0;
                r_wrap  <= 1'b0;
                r_ovf   <= 1'b0;
            end else if (load[i]) begin
                r_count <= load_value[i*WIDTH +: WIDTH];
                r_wrap  <= 1'b0;
            end else if (en[i]) begin
                if (w_at_bound) begin
                    r_ovf <= 1'b1;
                    if (sat[i]) begin
                        r_wrap <= 1'b0;
                    end else begin
                        r_count <= w_step;
                        r_wrap  <= 1'b1;
                    end
                end else begin
                    r_count <= w_step;
                    r_wrap  <= 1'b0;
                end
            end else begin
                r_wrap <= 1'b0;
            end
        end

        assign count_out[i*WIDTH +: WIDTH]        = r_count;
        assign wrap_pulse[i]                      = r_wrap;
        assign ovf_sticky[i]                      = r_ovf;
        assign w_snap[i*SLOT_WIDTH +: SLOT_WIDTH] = SLOT_WIDTH'(r_count);
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (snap_req) w_next_state = S_CAPTURE;
            S_CAPTURE: w_next_state = S_ACK;
            S_ACK:     if (!snap_req) w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge slower_clock or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ack   <= 1'b0;
            r_slots <= '0;
        end else begin
            r_state <= w_next_state;
            r_ack   <= (w_next_state == S_ACK);
            if (r_state == S_CAPTURE) begin
                r_slots <= w_snap;
            end
        end
    end

    assign snap_ack  = r_ack;
    assign slots_out = r_slots;

endmodule

// File: tb/tb_slot_counter_bank.sv
// Directed and randomized checks of slot_counter_bank against a behavioural
// model of the counters and snapshot handshake.
module tb_slot_counter_bank;

    localparam int CH   = 4;
    localparam int W    = 8;
    localparam int SW   = 32;
    localparam int MAXV = (1 << W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [CH-1:0]     en = '0, dir = '0, sat = '0, load = '0;
    logic [CH*W-1:0]   load_value = '0;
    logic              clear = 1'b0;
    logic              snap_req = 1'b0;
    logic              snap_ack;
    logic [CH*W-1:0]   count_out;
    logic [CH*SW-1:0]  slots_out;
    logic [CH-1:0]     wrap_pulse;
    logic [CH-1:0]     ovf_sticky;

    int tests = 0;
    int fails = 0;

    // behavioural model
    int unsigned m_cnt [CH];
    int unsigned m_slot[CH];
    bit          m_wp  [CH];
    bit          m_ovf [CH];
    bit          m_ack;
    bit          m_cap_pending;

    slot_counter_bank #(.CHANNELS(CH), .WIDTH(W), .SLOT_WIDTH(SW)) dut (
        .slower_clock(clk),
        .rst(rst),
        .en(en),
        .dir(dir),
        .sat(sat),
        .load(load),
        .load_value(load_value),
        .clear(clear),
        .snap_req(snap_req),
        .snap_ack(snap_ack),
        .count_out(count_out),
        .slots_out(slots_out),
        .wrap_pulse(wrap_pulse),
        .ovf_sticky(ovf_sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_cnt[i] = 0; m_slot[i] = 0; m_wp[i] = 0; m_ovf[i] = 0;
        end
        m_ack = 0;
        m_cap_pending = 0;
    endtask

    task automatic model_edge();
        // handshake sees pre-edge counts
        if (m_cap_pending) begin
            for (int i = 0; i < CH; i++) m_slot[i] = m_cnt[i];
            m_cap_pending = 0;
            m_ack = 1;
        end else if (m_ack) begin
            if (!snap_req) m_ack = 0;
        end else if (snap_req) begin
            m_cap_pending = 1;
        end
        for (int i = 0; i < CH; i++) begin
            if (clear) begin
                m_cnt[i] = 0; m_wp[i] = 0; m_ovf[i] = 0;
            end else if (load[i]) begin
                m_cnt[i] = load_value[i*W +: W];
                m_wp[i] = 0;
            end else if (en[i]) begin
                bit beyond;
                beyond = dir[i] ? (m_cnt[i] == 0) : (m_cnt[i] == MAXV);
                m_wp[i] = beyond && !sat[i];
                if (beyond) m_ovf[i] = 1;
                if (!(beyond && sat[i]))
                    m_cnt[i] = dir[i] ? (m_cnt[i] + MAXV) % (MAXV + 1) : (m_cnt[i] + 1) % (MAXV + 1);
            end else begin
                m_wp[i] = 0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [CH*W-1:0]  e_cnt;
        logic [CH*SW-1:0] e_slot;
        logic [CH-1:0]    e_wp, e_ovf;
        for (int i = 0; i < CH; i++) begin
            e_cnt[i*W +: W]    = W'(m_cnt[i]);
            e_slot[i*SW +: SW] = SW'(m_slot[i]);
            e_wp[i]            = m_wp[i];
            e_ovf[i]           = m_ovf[i];
        end
        chk({tag, ".count"}, 256'(count_out), 256'(e_cnt));
        chk({tag, ".slots"}, 256'(slots_out), 256'(e_slot));
        chk({tag, ".wrap"},  256'(wrap_pulse), 256'(e_wp));
        chk({tag, ".ovf"},   256'(ovf_sticky), 256'(e_ovf));
        chk({tag, ".ack"},   256'(snap_ack), 256'(m_ack));
    endtask

    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle_inputs();
        en = '0; dir = '0; sat = '0; load = '0; load_value = '0; clear = 0;
    endtask

    initial begin
        model_reset();
        rst = 1;
        #1;
        check_all("reset");
        @(posedge clk); #1;
        rst = 0;
        check_all("post_reset");

        // ch0 wrap up through 0xFF
        load = 4'b0001; load_value = 32'h0000_00FE;
        tick("ld_fe");
        load = '0; en = 4'b0001;
        tick("up_ff");
        chk("ch0_ff", 256'(count_out[7:0]), 256'(8'hFF));
        tick("up_wrap");
        chk("ch0_00", 256'(count_out[7:0]), 256'(8'h00));
        chk("wrap0_hi", 256'(wrap_pulse[0]), 256'(1'b1));
        chk("ovf0_set", 256'(ovf_sticky[0]), 256'(1'b1));
        tick("up_after");
        chk("wrap0_lo", 256'(wrap_pulse[0]), 256'(1'b0));
        chk("ovf0_sticky", 256'(ovf_sticky[0]), 256'(1'b1));

        // ch1 saturating down at zero
        idle_inputs(); clear = 1;
        tick("clear1");
        clear = 0; en = 4'b0010; dir = 4'b0010; sat = 4'b0010;
        for (int k = 0; k < 3; k++) tick("sat_dn");
        chk("ch1_hold", 256'(count_out[15:8]), 256'(8'h00));
        chk("wrap1_none", 256'(wrap_pulse[1]), 256'(1'b0));
        chk("ovf1_set", 256'(ovf_sticky[1]), 256'(1'b1));

        // load beats a boundary step; clear beats load
        idle_inputs(); clear = 1;
        tick("clear2");
        clear = 0; load = 4'b0100; load_value = 32'h00FF_0000;
        tick("ld_ff");
        load = 4'b0100; en = 4'b0100; load_value = 32'h0010_0000;
        tick("ld_vs_wrap");
        chk("ch2_10", 256'(count_out[23:16]), 256'(8'h10));
        chk("wrap2_none", 256'(wrap_pulse[2]), 256'(1'b0));
        chk("ovf2_clean", 256'(ovf_sticky[2]), 256'(1'b0));
        clear = 1;
        tick("clr_vs_ld");
        chk("ch2_00", 256'(count_out[23:16]), 256'(8'h00));

        // snapshot while ch0 counts from 5
        idle_inputs(); load = 4'b0001; load_value = 32'h0000_0005;
        tick("ld_05");
        load = '0; en = 4'b0001; snap_req = 1;
        tick("snap_e1");
        chk("ack_not_yet", 256'(snap_ack), 256'(1'b0));
        tick("snap_e2");
        chk("slot0_06", 256'(slots_out[31:0]), 256'(32'h0000_0006));
        chk("ack_hi", 256'(snap_ack), 256'(1'b1));
        tick("snap_hold");
        chk("slot0_stable", 256'(slots_out[31:0]), 256'(32'h0000_0006));
        snap_req = 0;
        tick("snap_drop");
        chk("ack_lo", 256'(snap_ack), 256'(1'b0));

        // reset aborts a handshake in ACK; held request captures afresh
        snap_req = 1;
        tick("r_e1");
        tick("r_e2");
        #2;
        rst = 1;
        #1;
        model_reset();
        check_all("mid_rst");
        chk("rst_ack", 256'(snap_ack), 256'(1'b0));
        @(posedge clk); #3;
        rst = 0;
        idle_inputs();
        tick("rel_e1");
        chk("rel_no_ack", 256'(snap_ack), 256'(1'b0));
        tick("rel_e2");
        chk("rel_ack", 256'(snap_ack), 256'(1'b1));
        chk("rel_slot", 256'(slots_out[31:0]), 256'(32'h0));
        snap_req = 0;
        tick("rel_drop");

        // randomized traffic biased toward boundaries
        for (int n = 0; n < 400; n++) begin
            en    = CH'($urandom);
            dir   = CH'($urandom);
            sat   = CH'($urandom);
            load  = CH'($urandom & $urandom & $urandom);
            clear = ($urandom_range(0, 29) == 0);
            for (int i = 0; i < CH; i++) begin
                case ($urandom_range(0, 3))
                    0:       load_value[i*W +: W] = '0;
                    1:       load_value[i*W +: W] = W'(MAXV);
                    default: load_value[i*W +: W] = W'($urandom);
                endcase
            end
            if ($urandom_range(0, 5) == 0) snap_req = ~snap_req;
            tick("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
